// File: rtl/riscv_fetch_stage.sv
// riscv_fetch_stage: RV32I instruction fetch with PC, IF/ID register, redirect, stall and flush handling
module riscv_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d,
  output logic        misaligned_d,
  output logic [31:0] fetch_cnt
);
  logic [31:0] pc_f;
  logic [31:0] pc_next;
  logic        mis_pend;
  logic        load;
  assign imem_addr = pc_f;
  assign load      = !flush_d && !stall_d;
  // next PC: redirect beats stall; redirect targets are forced to word alignment
  always_comb pc_next = redirect ? {redirect_pc[31:2], 2'b00} : stall_f ? pc_f : pc_f + 32'd4;
  // program counter register
  always_ff @(posedge clk) begin
    if (rst) pc_f <= RESET_PC;
    else     pc_f <= pc_next;
  end
  // pending misaligned-redirect flag, consumed by the next real IF/ID load
  always_ff @(posedge clk) begin
    if (rst)           mis_pend <= 1'b0;
    else if (redirect) mis_pend <= |redirect_pc[1:0];
    else if (load)     mis_pend <= 1'b0;
  end
  // IF/ID register: bubble on reset/flush, hold on stall, else capture the fetched word
  always_ff @(posedge clk) begin
    if (rst || flush_d) begin
      instr_d      <= NOP_INSTR;
      pc_d         <= 32'd0;
      pc_plus4_d   <= 32'd0;
      valid_d      <= 1'b0;
      misaligned_d <= 1'b0;
    end else if (!stall_d) begin
      instr_d      <= imem_rd;
      pc_d         <= pc_f;
      pc_plus4_d   <= pc_f + 32'd4;
      valid_d      <= 1'b1;
      misaligned_d <= mis_pend;
    end
  end
  // bring-up counter of instructions accepted into IF/ID
  always_ff @(posedge clk) begin
    if (rst)       fetch_cnt <= 32'd0;
    else if (load) fetch_cnt <= fetch_cnt + 32'd1;
  end
endmodule
